// File: rtl/clock_monitor_pkg.sv
// Shared definitions for the clock monitor: FSM state encoding and state helpers.
package clock_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        LOCKED  = 2'd3
    } state_e;

    // True in the states where measured intervals are reported.
    function automatic logic is_measuring(input state_e st);
        return (st == MEASURE) || (st == LOCKED);
    endfunction

endpackage

// File: rtl/clock_monitor_sync_edge_detect.sv
// Two-flop synchronizer plus history flop for the monitored clock, with
// registered single-cycle rise and fall strobes.
module sync_edge_detect
    import clock_monitor_pkg::*;
(
    input  logic clk_in,
    input  logic reset,
    input  logic d_in,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic hist_q, hist_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Next-state of the synchronizer chain and edge strobes.
    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
        hist_d = sync_q;
        rise_d = sync_q & ~hist_q;
        fall_d = ~sync_q & hist_q;
    end

    // Synchronizer, history and strobe registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            hist_q <= hist_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sync = sync_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/clock_monitor.sv
// Measures period and high time of a slow clock sampled as data, tracks lock
// against a nominal period and raises a sticky fault on lock loss or timeout.
module clock_monitor
    import clock_monitor_pkg::*;
#(
    parameter int CNT_WIDTH       = 16,
    parameter int EXPECTED_PERIOD = 10,
    parameter int TOLERANCE       = 1,
    parameter int LOCK_COUNT      = 4
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 clk_mon,
    input  logic                 enable,
    input  logic                 clear_fault,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 period_valid,
    output logic                 locked,
    output logic                 fault
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH:0]   EXP_W     = (CNT_WIDTH + 1)'(EXPECTED_PERIOD);
    localparam logic [CNT_WIDTH:0]   TOL_W     = (CNT_WIDTH + 1)'(TOLERANCE);
    localparam logic [MW-1:0]        LOCK_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [MW-1:0]        LOCK_FULL = MW'(LOCK_COUNT);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [MW-1:0]        match_q, match_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] high_q, high_d;
    logic                 pv_q, pv_d;
    logic                 locked_q, locked_d;
    logic                 fault_q, fault_d;

    logic                 sync_unused_s;
    logic                 rise_s;
    logic                 fall_s;
    logic                 fault_event_s;
    logic                 in_tol_s;
    logic [CNT_WIDTH:0]   cnt_ext_s;
    logic [CNT_WIDTH:0]   diff_s;

    sync_edge_detect u_sync (
        .clk_in (clk_in),
        .reset  (reset),
        .d_in   (clk_mon),
        .sync   (sync_unused_s),
        .rise   (rise_s),
        .fall   (fall_s)
    );

    // Absolute distance of the running count from the nominal period, one bit wider so it cannot wrap.
    always_comb begin
        cnt_ext_s = {1'b0, cnt_q};
        if (cnt_ext_s >= EXP_W) begin
            diff_s = cnt_ext_s - EXP_W;
        end else begin
            diff_s = EXP_W - cnt_ext_s;
        end
        in_tol_s = (diff_s <= TOL_W);
    end

    // FSM next state, interval counter, measurements, lock and fault.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        match_d       = match_q;
        period_d      = period_q;
        high_d        = high_q;
        pv_d          = 1'b0;
        locked_d      = locked_q;
        fault_event_s = 1'b0;

        if (!enable) begin
            state_d  = IDLE;
            cnt_d    = {CNT_WIDTH{1'b0}};
            match_d  = {MW{1'b0}};
            locked_d = 1'b0;
        end else begin
            if (rise_s) begin
                cnt_d = CNT_WIDTH'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end else begin
                cnt_d = cnt_q;
            end

            if (is_measuring(state_q) && fall_s) begin
                high_d = cnt_q;
            end else begin
                high_d = high_q;
            end

            case (state_q)
                IDLE: begin
                    state_d = ARM;
                end
                ARM: begin
                    // The interval before the first rise is partial and is never reported.
                    if (rise_s) begin
                        state_d = MEASURE;
                    end else begin
                        state_d = ARM;
                    end
                end
                MEASURE, LOCKED: begin
                    if (rise_s) begin
                        period_d = cnt_q;
                        pv_d     = 1'b1;
                        if (in_tol_s) begin
                            if (state_q == MEASURE && match_q == LOCK_LAST) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                                match_d  = LOCK_FULL;
                            end else if (state_q == MEASURE) begin
                                match_d = match_q + MW'(1);
                            end else begin
                                match_d = match_q;
                            end
                        end else begin
                            match_d = {MW{1'b0}};
                            if (state_q == LOCKED) begin
                                fault_event_s = 1'b1;
                                locked_d      = 1'b0;
                                state_d       = MEASURE;
                            end else begin
                                state_d = MEASURE;
                            end
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        fault_event_s = 1'b1;
                        locked_d      = 1'b0;
                        match_d       = {MW{1'b0}};
                        state_d       = ARM;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // A new fault event takes priority over a clear request in the same cycle.
        if (fault_event_s) begin
            fault_d = 1'b1;
        end else if (clear_fault) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= {CNT_WIDTH{1'b0}};
            match_q  <= {MW{1'b0}};
            period_q <= {CNT_WIDTH{1'b0}};
            high_q   <= {CNT_WIDTH{1'b0}};
            pv_q     <= 1'b0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            match_q  <= match_d;
            period_q <= period_d;
            high_q   <= high_d;
            pv_q     <= pv_d;
            locked_q <= locked_d;
            fault_q  <= fault_d;
        end
    end

    assign period       = period_q;
    assign high_time    = high_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Scoreboard bench for clock_monitor: pulse trains on clk_mon are scored by a
// reference model of the lock rules; a monitor compares every period report.
module tb_clock_monitor;

    localparam int CW  = 16;
    localparam int EXP = 10;
    localparam int TOL = 1;
    localparam int LCK = 4;

    logic          clk_in = 1'b0;
    logic          reset;
    logic          clk_mon;
    logic          enable;
    logic          clear_fault;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          period_valid;
    logic          locked;
    logic          fault;

    clock_monitor #(
        .CNT_WIDTH       (CW),
        .EXPECTED_PERIOD (EXP),
        .TOLERANCE       (TOL),
        .LOCK_COUNT      (LCK)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .clk_mon      (clk_mon),
        .enable       (enable),
        .clear_fault  (clear_fault),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .locked       (locked),
        .fault        (fault)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int unsigned per;
        int unsigned hi;
        bit          lk;
        bit          flt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: pulses seen since arming, consecutive matches, lock, sticky fault.
    int m_idx, m_match, prev_p, prev_h;
    bit m_locked, m_fault;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic model_restart();
        m_idx    = 0;
        m_match  = 0;
        m_locked = 1'b0;
    endtask

    // Score one completed interval (period p, high h) and queue the expected report.
    task automatic model_report(input int p, input int h);
        exp_t e;
        int   d;
        bit   ok;
        d  = (p > EXP) ? (p - EXP) : (EXP - p);
        ok = (d <= TOL);
        if (m_locked) begin
            if (!ok) begin
                m_fault  = 1'b1;
                m_locked = 1'b0;
                m_match  = 0;
            end
        end else if (ok) begin
            m_match++;
            if (m_match == LCK) m_locked = 1'b1;
        end else begin
            m_match = 0;
        end
        e.per = p;
        e.hi  = h;
        e.lk  = m_locked;
        e.flt = m_fault;
        exp_q.push_back(e);
    endtask

    // One clk_mon cycle: high for h clk_in cycles, low for p-h; a rise closes the previous interval.
    task automatic send_pulse(input int p, input int h, input bit chk_lat = 1'b0);
        if (m_idx > 0) model_report(prev_p, prev_h);
        m_idx++;
        prev_p  = p;
        prev_h  = h;
        clk_mon = 1'b1;
        if (chk_lat) begin
            repeat (3) tick();
            check("pv_latency_early", period_valid, 0);
            tick();
            check("pv_latency_3", period_valid, (m_idx > 1) ? 1 : 0);
            repeat (h - 4) tick();
        end else begin
            repeat (h) tick();
        end
        clk_mon = 1'b0;
        repeat (p - h) tick();
    endtask

    // Monitor: every period report must match the oldest queued expectation.
    always @(negedge clk_in) begin
        if (period_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_period_valid: actual period=%0d required=no report", period);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_period", period, mon_e.per);
                check("sb_high_time", high_time, mon_e.hi);
                check("sb_locked", locked, mon_e.lk);
                check("sb_fault", fault, mon_e.flt);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: actual=time limit reached required=bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int p;
        int r;
        reset       = 1'b1;
        enable      = 1'b0;
        clk_mon     = 1'b0;
        clear_fault = 1'b0;
        m_fault     = 1'b0;
        prev_p      = 0;
        prev_h      = 0;
        model_restart();

        repeat (20) tick();
        check("rst_period", period, 0);
        check("rst_high_time", high_time, 0);
        check("rst_period_valid", period_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_fault", fault, 0);
        reset = 1'b0;
        tick();

        // Steady nominal clock: lock after 1 arming rise plus 4 matches.
        enable = 1'b1;
        repeat (3) tick();
        repeat (6) send_pulse(10, 5);
        check("locked_after_5_rises", locked, 1);

        // One long period while locked, then recovery.
        send_pulse(14, 7);
        repeat (5) send_pulse(10, 5);
        check("relocked_after_4_periods", locked, 1);

        // Edge-of-tolerance periods count as matches; 12 clears the run.
        send_pulse(12, 6);
        send_pulse(11, 5);
        send_pulse(9, 4);
        send_pulse(12, 6);
        repeat (4) send_pulse(10, 5);
        check("match_cleared_by_12", locked, 0);
        send_pulse(10, 5);
        check("locked_after_clear", locked, 1);

        // Randomized periods around nominal.
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            p = (r < 2) ? 8 : (r < 4) ? 9 : (r < 6) ? 10 : (r < 8) ? 11 : 12;
            send_pulse(p, int'($urandom_range(1, p - 1)));
        end
        repeat (6) send_pulse(10, 5);
        check("locked_before_disable", locked, 1);

        // Disable while locked: lock drops, measurements hold.
        enable = 1'b0;
        tick();
        check("disable_locked", locked, 0);
        check("disable_period_hold", period, 10);
        check("disable_high_hold", high_time, 5);
        model_restart();
        repeat (3) tick();

        // Timeout in MEASURE with clear_fault held through the timeout cycle.
        enable = 1'b1;
        repeat (2) tick();
        send_pulse(10, 5);
        send_pulse(10, 5);
        clear_fault = 1'b1;
        tick();
        check("clear_fault_alone", fault, 0);
        m_fault = 1'b0;
        n = 0;
        while (fault !== 1'b1 && n < 70000) begin
            tick();
            n++;
        end
        check("timeout_fault", fault, 1);
        check("timeout_cycles_in_range", (n >= 65000 && n <= 66000) ? 1 : 0, 1);
        check("timeout_locked", locked, 0);
        clear_fault = 1'b0;
        tick();
        check("fault_beats_clear", fault, 1);
        m_fault = 1'b1;
        model_restart();
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        m_fault = 1'b0;
        check("clear_after_timeout", fault, 0);

        // Back in ARM: the first rise is not reported; check report latency.
        send_pulse(10, 5);
        send_pulse(10, 5, 1'b1);
        repeat (4) send_pulse(10, 5);
        check("locked_before_reset", locked, 1);

        // Reset in the very cycle a rise reaches the FSM.
        clk_mon = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("rst_rise_period", period, 0);
        check("rst_rise_high_time", high_time, 0);
        check("rst_rise_period_valid", period_valid, 0);
        check("rst_rise_locked", locked, 0);
        check("rst_rise_fault", fault, 0);
        clk_mon = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
